// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared op/state enums, flag bit positions and op-class helpers for seq_alu
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_AND, OP_OR, OP_XOR,
        OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR,
        OP_MUL, OP_IMUL
    } seq_alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_SHIFT, ST_MUL, ST_DONE
    } seq_alu_state_t;

    localparam int CF_IDX = 0;
    localparam int PF_IDX = 2;
    localparam int AF_IDX = 4;
    localparam int ZF_IDX = 6;
    localparam int SF_IDX = 7;
    localparam int OF_IDX = 11;

    function automatic logic is_shift_op(input seq_alu_op_t op);
        return op inside {OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR};
    endfunction

    function automatic logic is_mul_op(input seq_alu_op_t op);
        return op inside {OP_MUL, OP_IMUL};
    endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// rtl/seq_alu_shifter.sv - one-bit shift/rotate step at effective width 8 or WIDTH
module seq_alu_shifter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  seq_alu_op_t      op_i,
    input  logic             is_8_bit_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic             cf_i,
    output logic [WIDTH-1:0] val_o,
    output logic             cf_o
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] top_bit;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic             msb;

    always_comb begin
        mask    = is_8_bit_i ? WIDTH'(8'hFF) : '1;
        top_bit = is_8_bit_i ? WIDTH'(8'h80) : {1'b1, {(WIDTH-1){1'b0}}};
        msb     = |(val_i & top_bit);
        shl     = (val_i << 1) & mask;
        shr     = (val_i & mask) >> 1;
        val_o   = val_i;
        cf_o    = cf_i;
        // Right-moving ops insert at bit E-1; left-moving ops insert at bit 0.
        case (op_i)
            OP_SHL: begin val_o = shl;                              cf_o = msb;      end
            OP_SHR: begin val_o = shr;                              cf_o = val_i[0]; end
            OP_SAR: begin val_o = shr | (msb ? top_bit : '0);       cf_o = val_i[0]; end
            OP_ROL: begin val_o = shl | WIDTH'(msb);                cf_o = msb;      end
            OP_ROR: begin val_o = shr | (val_i[0] ? top_bit : '0);  cf_o = val_i[0]; end
            OP_RCL: begin val_o = shl | WIDTH'(cf_i);               cf_o = msb;      end
            OP_RCR: begin val_o = shr | (cf_i ? top_bit : '0);      cf_o = val_i[0]; end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: 1-cycle ALU ops, bit-serial shifts, shift-add MUL/IMUL
// SEQ_ALU_FAST_MUL_EN selects a single-cycle combinational multiplier instead of the MUL state.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic               is_8_bit,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [15:0]        flags_in,
    output logic [2*WIDTH-1:0] out,
    output logic [15:0]        flags_out,
    output logic               busy,
    output logic               complete
);

    localparam int CW = (CNT_BITS > 6) ? CNT_BITS : 6;
    localparam int PW = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] e_mask(input logic is8);
        return is8 ? WIDTH'(8'hFF) : '1;
    endfunction

    function automatic logic e_msb(input logic [WIDTH-1:0] v, input logic is8);
        return is8 ? v[7] : v[WIDTH-1];
    endfunction

    function automatic logic e_msb2(input logic [WIDTH-1:0] v, input logic is8);
        return is8 ? v[6] : v[WIDTH-2];
    endfunction

    // Applies the IMUL sign fix-up, trims to 2E bits and reports upper-half significance.
    function automatic logic [PW:0] mul_finish(input logic [PW-1:0] p, input logic neg,
                                               input logic is8, input logic sgn);
        logic [PW-1:0] r;
        logic          ovf;
        r = neg ? (~p + PW'(1)) : p;
        if (is8) begin
            r   = r & PW'(16'hFFFF);
            ovf = sgn ? (r[15:8] != {8{r[7]}}) : (r[15:8] != 8'h00);
        end else begin
            ovf = sgn ? (r[PW-1:WIDTH] != {WIDTH{r[WIDTH-1]}}) : (r[PW-1:WIDTH] != '0);
        end
        return {ovf, r};
    endfunction

    seq_alu_state_t   state_q, state_d;
    seq_alu_op_t      op_q, op_d, op_in;
    logic             is8_q, is8_d;
    logic [15:0]      fl_q, fl_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             cf_q, cf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             one_q, one_d;
    logic             omsb_q, omsb_d;
    logic [PW-1:0]    out_q, out_d;
    logic [15:0]      flags_q, flags_d;

    logic [WIDTH-1:0] mask_in, am, bm, alu_res, a_abs, b_abs;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    count_in;
    logic             a_neg, b_neg, sub_op, carry_in;
    logic [15:0]      alu_flags, sh_flags, mul_flags;
    logic [WIDTH-1:0] sh_val;
    logic             sh_cf;
    logic [PW-1:0]    mul_res;
    logic             mul_ovf;

    assign op_in = seq_alu_op_t'(op);

    always_comb begin
        mask_in  = e_mask(is_8_bit);
        am       = a & mask_in;
        bm       = b & mask_in;
        count_in = CW'(b[CNT_BITS-1:0]);
        sub_op   = op_in inside {OP_SUB, OP_SBB};
        carry_in = (op_in inside {OP_ADC, OP_SBB}) & flags_in[CF_IDX];
        sum      = sub_op ? ({1'b0, am} - {1'b0, bm} - (WIDTH+1)'(carry_in))
                          : ({1'b0, am} + {1'b0, bm} + (WIDTH+1)'(carry_in));
        alu_res  = sum[WIDTH-1:0] & mask_in;
        case (op_in)
            OP_AND:  alu_res = am & bm;
            OP_OR:   alu_res = am | bm;
            OP_XOR:  alu_res = am ^ bm;
            default: ;
        endcase
        alu_flags = flags_in;
        if (op_in inside {OP_AND, OP_OR, OP_XOR}) begin
            alu_flags[CF_IDX] = 1'b0;
            alu_flags[OF_IDX] = 1'b0;
        end else begin
            alu_flags[CF_IDX] = is_8_bit ? sum[8] : sum[WIDTH];
            alu_flags[AF_IDX] = am[4] ^ bm[4] ^ alu_res[4];
            alu_flags[OF_IDX] = (sub_op ? (e_msb(am, is_8_bit) != e_msb(bm, is_8_bit))
                                        : (e_msb(am, is_8_bit) == e_msb(bm, is_8_bit)))
                                && (e_msb(alu_res, is_8_bit) != e_msb(am, is_8_bit));
        end
        alu_flags[SF_IDX] = e_msb(alu_res, is_8_bit);
        alu_flags[ZF_IDX] = (alu_res == '0);
        alu_flags[PF_IDX] = ~^alu_res[7:0];

        a_neg = (op_in == OP_IMUL) && e_msb(am, is_8_bit);
        b_neg = (op_in == OP_IMUL) && e_msb(bm, is_8_bit);
        a_abs = a_neg ? ((~am + WIDTH'(1)) & mask_in) : am;
        b_abs = b_neg ? ((~bm + WIDTH'(1)) & mask_in) : bm;
    end

    seq_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .op_i       (op_q),
        .is_8_bit_i (is8_q),
        .val_i      (val_q),
        .cf_i       (cf_q),
        .val_o      (sh_val),
        .cf_o       (sh_cf)
    );

    always_comb begin
        sh_flags         = fl_q;
        sh_flags[CF_IDX] = sh_cf;
        if (one_q) begin
            case (op_q)
                OP_SHL, OP_ROL, OP_RCL: sh_flags[OF_IDX] = e_msb(sh_val, is8_q) ^ sh_cf;
                OP_SHR:                 sh_flags[OF_IDX] = omsb_q;
                OP_SAR:                 sh_flags[OF_IDX] = 1'b0;
                default:                sh_flags[OF_IDX] = e_msb(sh_val, is8_q) ^ e_msb2(sh_val, is8_q);
            endcase
        end
        if (op_q inside {OP_SHL, OP_SHR, OP_SAR}) begin
            sh_flags[SF_IDX] = e_msb(sh_val, is8_q);
            sh_flags[ZF_IDX] = (sh_val == '0);
            sh_flags[PF_IDX] = ~^sh_val[7:0];
        end
    end

`ifdef SEQ_ALU_FAST_MUL_EN
    assign {mul_ovf, mul_res} = mul_finish(PW'(a_abs) * PW'(b_abs), a_neg ^ b_neg,
                                           is_8_bit, op_in == OP_IMUL);
    always_comb begin
        mul_flags         = flags_in;
        mul_flags[CF_IDX] = mul_ovf;
        mul_flags[OF_IDX] = mul_ovf;
    end
`else
    logic [PW-1:0]    prod_q, mcand_q, prod_nx;
    logic [WIDTH-1:0] mplier_q;
    logic             neg_q;
    logic             mul_load;

    assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign {mul_ovf, mul_res} = mul_finish(prod_nx, neg_q, is8_q, op_q == OP_IMUL);

    always_comb begin
        mul_flags         = fl_q;
        mul_flags[CF_IDX] = mul_ovf;
        mul_flags[OF_IDX] = mul_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else if (mul_load) begin
            prod_q   <= '0;
            mcand_q  <= PW'(a_abs);
            mplier_q <= b_abs;
            neg_q    <= a_neg ^ b_neg;
        end else if (state_q == ST_MUL) begin
            prod_q   <= prod_nx;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        is8_d   = is8_q;
        fl_d    = fl_q;
        val_d   = val_q;
        cf_d    = cf_q;
        cnt_d   = cnt_q;
        one_d   = one_q;
        omsb_d  = omsb_q;
        out_d   = out_q;
        flags_d = flags_q;
`ifndef SEQ_ALU_FAST_MUL_EN
        mul_load = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    op_d  = op_in;
                    is8_d = is_8_bit;
                    fl_d  = flags_in;
                    if (is_shift_op(op_in)) begin
                        if (count_in == '0) begin
                            out_d   = PW'(am);
                            flags_d = flags_in;
                            state_d = ST_DONE;
                        end else begin
                            val_d   = am;
                            cf_d    = flags_in[CF_IDX];
                            cnt_d   = count_in;
                            one_d   = (count_in == CW'(1));
                            omsb_d  = e_msb(am, is_8_bit);
                            state_d = ST_SHIFT;
                        end
                    end else if (is_mul_op(op_in)) begin
`ifdef SEQ_ALU_FAST_MUL_EN
                        out_d   = mul_res;
                        flags_d = mul_flags;
                        state_d = ST_DONE;
`else
                        mul_load = 1'b1;
                        cnt_d    = is_8_bit ? CW'(8) : CW'(WIDTH);
                        state_d  = ST_MUL;
`endif
                    end else begin
                        out_d   = PW'(alu_res);
                        flags_d = alu_flags;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                val_d = sh_val;
                cf_d  = sh_cf;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d   = PW'(sh_val);
                    flags_d = sh_flags;
                    state_d = ST_DONE;
                end
            end
`ifndef SEQ_ALU_FAST_MUL_EN
            ST_MUL: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d   = mul_res;
                    flags_d = mul_flags;
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            is8_q   <= 1'b0;
            fl_q    <= '0;
            val_q   <= '0;
            cf_q    <= 1'b0;
            cnt_q   <= '0;
            one_q   <= 1'b0;
            omsb_q  <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            is8_q   <= is8_d;
            fl_q    <= fl_d;
            val_q   <= val_d;
            cf_q    <= cf_d;
            cnt_q   <= cnt_d;
            one_q   <= one_d;
            omsb_q  <= omsb_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out       = out_q;
    assign flags_out = flags_q;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_MUL);
    assign complete  = (state_q == ST_DONE);

endmodule
